// File: rtl/snk_input_cond.sv
// snk_input_cond: debounces the hps_io joystick word, shapes coin and pause, builds PLAYER1.
// Build option SNK_COIN_COUNTER_EN adds the coin_count counter; coin_state_o encodes IDLE=0 PULSE=1 GAP=2 HOLD=3.
module snk_input_cond #(
  parameter int DEB_CYCLES      = 53600,
  parameter int COIN_LOW_CYCLES = 5360000,
  parameter int COIN_GAP_CYCLES = 5360000
) (
  input  logic        i_clk,
  input  logic        RESETn,
  input  logic [15:0] joystick,
  output logic [15:0] PLAYER1,
  output logic        pause_out,
  output logic [7:0]  coin_count,
  output logic [1:0]  coin_state_o
);

  localparam int PW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int CMAX = (COIN_LOW_CYCLES > COIN_GAP_CYCLES) ? COIN_LOW_CYCLES : COIN_GAP_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] LOW_LAST = CW'(COIN_LOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(COIN_GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_HOLD  = 2'd3
  } coin_state_e;

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;
  logic [11:0]   samp_q, samp_d;
  logic [11:0]   deb_q, deb_d;
  logic [11:0]   agree;
  logic          deb9_prev_q;
  logic          pause_q, pause_d;
  coin_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   p1_q, p1_d;
  logic          up_c, dn_c, rt_c, lf_c;
  logic          unused_hi;

  assign unused_hi = ^joystick[15:12];

  // A bit is accepted only when two consecutive tick samples agree.
  always_comb begin
    tick   = (pre_q == PRE_LAST);
    pre_d  = tick ? '0 : pre_q + PW'(1);
    agree  = ~(samp_q ^ joystick[11:0]);
    samp_d = samp_q;
    deb_d  = deb_q;
    if (tick) begin
      samp_d = joystick[11:0];
      deb_d  = (agree & joystick[11:0]) | (~agree & deb_q);
    end
  end

  assign pause_d = pause_q ^ (deb_q[9] & ~deb9_prev_q);

  // Coin FSM is frozen entirely while paused.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!pause_q) begin
      case (state_q)
        ST_IDLE: begin
          if (deb_q[8]) begin
            state_d = ST_PULSE;
            cnt_d   = '0;
          end
        end
        ST_PULSE: begin
          if (cnt_q == LOW_LAST) begin
            state_d = ST_GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_HOLD: begin
          if (!deb_q[8]) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Opposing directions pressed together cancel each other out.
  always_comb begin
    up_c = deb_q[3] & ~deb_q[2];
    dn_c = deb_q[2] & ~deb_q[3];
    rt_c = deb_q[0] & ~deb_q[1];
    lf_c = deb_q[1] & ~deb_q[0];
    p1_d = {2'b11, ~up_c, ~dn_c, ~rt_c, ~lf_c, ~deb_q[10], ~deb_q[11], 3'b111,
            ~deb_q[6], ~deb_q[5], ~deb_q[4], ~deb_q[7], (state_q != ST_PULSE)};
  end

  always_ff @(posedge i_clk) begin
    if (!RESETn) begin
      pre_q       <= '0;
      samp_q      <= '0;
      deb_q       <= '0;
      deb9_prev_q <= 1'b0;
      pause_q     <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      p1_q        <= 16'hFFFF;
    end else begin
      pre_q       <= pre_d;
      samp_q      <= samp_d;
      deb_q       <= deb_d;
      deb9_prev_q <= deb_q[9];
      pause_q     <= pause_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p1_q        <= p1_d;
    end
  end

`ifdef SNK_COIN_COUNTER_EN
  logic [7:0] coins_q;
  logic       coin_start;

  assign coin_start = !pause_q && (state_q == ST_IDLE) && deb_q[8];

  always_ff @(posedge i_clk) begin
    if (!RESETn) begin
      coins_q <= 8'h00;
    end else if (coin_start) begin
      coins_q <= coins_q + 8'd1;
    end
  end

  assign coin_count = coins_q;
`else
  assign coin_count = 8'h00;
`endif

  assign PLAYER1      = p1_q;
  assign pause_out    = pause_q;
  assign coin_state_o = state_q;

endmodule

// File: tb/tb_snk_input_cond.sv
// Self-checking bench for snk_input_cond: directed scenarios plus randomized joystick traffic
// compared against a timestamp-style behavioural model.
module tb_snk_input_cond;

  localparam int DEB = 4;
  localparam int LOW = 8;
  localparam int GAP = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] joy;
  logic [15:0] p1;
  logic        pause_o;
  logic [7:0]  cc;
  logic [1:0]  st;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  snk_input_cond #(
    .DEB_CYCLES(DEB),
    .COIN_LOW_CYCLES(LOW),
    .COIN_GAP_CYCLES(GAP)
  ) dut (
    .i_clk(clk),
    .RESETn(rst_n),
    .joystick(joy),
    .PLAYER1(p1),
    .pause_out(pause_o),
    .coin_count(cc),
    .coin_state_o(st)
  );

  // Reference model: cycles since reset, last tick sample, accepted buttons, and a coin
  // "elapsed active time" stamp that only advances while not paused.
  int          m_cycles;
  logic [11:0] m_samp, m_deb;
  logic        m_deb9_prev, m_pause, m_busy;
  int          m_el;
  logic [7:0]  m_cc;
  logic [15:0] m_p1;

  function automatic logic [15:0] build(logic [11:0] d, logic coin_low);
    logic up, dn, rt, lf;
    up = d[3] && !d[2];
    dn = d[2] && !d[3];
    rt = d[0] && !d[1];
    lf = d[1] && !d[0];
    build = 16'hFFFF;
    build[13] = !up;    build[12] = !dn;    build[11] = !rt;   build[10] = !lf;
    build[9]  = !d[10]; build[8]  = !d[11]; build[4]  = !d[6]; build[3]  = !d[5];
    build[2]  = !d[4];  build[1]  = !d[7];  build[0]  = !coin_low;
  endfunction

  function automatic logic [7:0] exp_cc();
`ifdef SNK_COIN_COUNTER_EN
    exp_cc = m_cc;
`else
    exp_cc = 8'h00;
`endif
  endfunction

  function automatic logic [7:0] exp_cc_const(int n);
`ifdef SNK_COIN_COUNTER_EN
    exp_cc_const = 8'(n);
`else
    exp_cc_const = 8'h00;
`endif
  endfunction

  function automatic logic [1:0] exp_phase();
    if (!m_busy) exp_phase = 2'd0;
    else if (m_el < LOW) exp_phase = 2'd1;
    else if (m_el < LOW + GAP) exp_phase = 2'd2;
    else exp_phase = 2'd3;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cycles = 0; m_samp = '0; m_deb = '0; m_deb9_prev = 1'b0;
      m_pause = 1'b0; m_busy = 1'b0; m_el = 0; m_cc = 8'h00; m_p1 = 16'hFFFF;
    end else begin
      m_p1 = build(m_deb, m_busy && (m_el < LOW));
      if (!m_pause) begin
        if (!m_busy) begin
          if (m_deb[8]) begin m_busy = 1'b1; m_el = 0; m_cc = m_cc + 8'd1; end
        end else if (m_el < LOW + GAP) begin
          m_el = m_el + 1;
        end else if (!m_deb[8]) begin
          m_busy = 1'b0;
        end
      end
      if (m_deb[9] && !m_deb9_prev) m_pause = !m_pause;
      m_deb9_prev = m_deb[9];
      if (m_cycles % DEB == DEB - 1) begin
        for (int i = 0; i < 12; i++) if (joy[i] == m_samp[i]) m_deb[i] = joy[i];
        m_samp = joy[11:0];
      end
      m_cycles = m_cycles + 1;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; joy = 16'h0FFF;
    repeat (4) begin
      @(negedge clk);
      n_tests++;
      if (p1 !== 16'hFFFF || pause_o !== 1'b0 || cc !== 8'h00)
        begin n_fail++; $display("FAIL reset_hold p1=%h pause=%b cc=%0d want FFFF/0/0", p1, pause_o, cc); end
    end
    rst_n = 1'b1; joy = 16'h0000;
    repeat (12) begin
      @(negedge clk);
      n_tests++;
      if (p1 !== 16'hFFFF || p1 !== m_p1)
        begin n_fail++; $display("FAIL reset_release p1=%h want FFFF", p1); end
    end
  endtask

  task automatic test_debounce();
    int lat, rel;
    joy = 16'h0010;
    repeat (2) @(negedge clk);
    joy = 16'h0000;
    repeat (12) begin
      @(negedge clk);
      n_tests++;
      if (p1 !== 16'hFFFF || p1 !== m_p1)
        begin n_fail++; $display("FAIL glitch p1=%h want FFFF", p1); end
    end
    joy = 16'h0010; lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      n_tests++;
      if (p1 !== m_p1) begin n_fail++; $display("FAIL fire_press p1=%h want %h", p1, m_p1); end
      if (lat == 0 && p1[2] == 1'b0) lat = k;
    end
    n_tests++;
    if (lat < DEB + 1 || lat > 2 * DEB + 1)
      begin n_fail++; $display("FAIL fire_latency got %0d want %0d..%0d", lat, DEB + 1, 2 * DEB + 1); end
    joy = 16'h0000; rel = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      n_tests++;
      if (p1 !== m_p1) begin n_fail++; $display("FAIL fire_release p1=%h want %h", p1, m_p1); end
      if (rel == 0 && p1[2] == 1'b1) rel = k;
    end
    n_tests++;
    if (rel < DEB || rel > 2 * DEB + 1)
      begin n_fail++; $display("FAIL release_latency got %0d want %0d..%0d", rel, DEB, 2 * DEB + 1); end
  endtask

  task automatic test_directions();
    joy = 16'h000F;
    repeat (20) begin
      @(negedge clk);
      n_tests++;
      if (p1 !== m_p1) begin n_fail++; $display("FAIL dirs_all p1=%h want %h", p1, m_p1); end
    end
    n_tests++;
    if (p1[13:10] !== 4'b1111) begin n_fail++; $display("FAIL dirs_cancel got %b want 1111", p1[13:10]); end
    joy = 16'h0009;
    repeat (20) begin
      @(negedge clk);
      n_tests++;
      if (p1 !== m_p1) begin n_fail++; $display("FAIL dirs_ur p1=%h want %h", p1, m_p1); end
    end
    n_tests++;
    if (p1[13:10] !== 4'b0101) begin n_fail++; $display("FAIL dirs_up_right got %b want 0101", p1[13:10]); end
    joy = 16'h0000;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_coin();
    int lows, pulses;
    logic prev;
    for (int r = 1; r <= 2; r++) begin
      joy = 16'h0100; lows = 0; pulses = 0; prev = 1'b1;
      repeat ((r == 1) ? 100 : 40) begin
        @(negedge clk);
        n_tests++;
        if (p1 !== m_p1 || cc !== exp_cc())
          begin n_fail++; $display("FAIL coin_model p1=%h want %h cc=%0d want %0d", p1, m_p1, cc, exp_cc()); end
        if (p1[0] == 1'b0) lows++;
        if (prev == 1'b1 && p1[0] == 1'b0) pulses++;
        prev = p1[0];
      end
      n_tests++;
      if (lows != LOW || pulses != 1)
        begin n_fail++; $display("FAIL coin_pulse%0d low=%0d pulses=%0d want %0d/1", r, lows, pulses, LOW); end
      n_tests++;
      if (cc !== exp_cc_const(r)) begin n_fail++; $display("FAIL coin_count%0d got %0d want %0d", r, cc, exp_cc_const(r)); end
      joy = 16'h0000;
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic test_pause();
    int lows, toggles;
    logic prev;
    joy = 16'h0200;
    repeat (12) @(negedge clk);
    joy = 16'h0000;
    repeat (12) @(negedge clk);
    n_tests++;
    if (pause_o !== 1'b1) begin n_fail++; $display("FAIL pause_on got %b want 1", pause_o); end
    joy = 16'h0100;
    repeat (30) begin
      @(negedge clk);
      n_tests++;
      if (p1[0] !== 1'b1 || pause_o !== 1'b1 || p1 !== m_p1)
        begin n_fail++; $display("FAIL coin_while_paused p1=%h pause=%b want %h/1", p1, pause_o, m_p1); end
    end
    lows = 0;
    joy = 16'h0300;
    for (int k = 0; k < 42; k++) begin
      if (k == 12) joy = 16'h0100;
      @(negedge clk);
      n_tests++;
      if (p1 !== m_p1 || pause_o !== m_pause)
        begin n_fail++; $display("FAIL unpause p1=%h pause=%b want %h/%b", p1, pause_o, m_p1, m_pause); end
      if (p1[0] == 1'b0) lows++;
    end
    n_tests++;
    if (pause_o !== 1'b0 || lows != LOW)
      begin n_fail++; $display("FAIL unpause_pulse pause=%b low=%0d want 0/%0d", pause_o, lows, LOW); end
    joy = 16'h0200; toggles = 0; prev = pause_o;
    repeat (50) begin
      @(negedge clk);
      if (pause_o !== prev) toggles++;
      prev = pause_o;
    end
    n_tests++;
    if (toggles != 1) begin n_fail++; $display("FAIL pause_hold toggles=%0d want 1", toggles); end
    joy = 16'h0000;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid_pulse();
    int found;
    rst_n = 1'b0; joy = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1; joy = 16'h0100; found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk);
      if (p1[0] == 1'b0) found = 1;
    end
    n_tests++;
    if (found == 0) begin n_fail++; $display("FAIL mid_pulse_start no pulse within 20 cycles"); end
    repeat (2) @(negedge clk);
    n_tests++;
    if (st !== 2'd1 || p1[0] !== 1'b0) begin n_fail++; $display("FAIL mid_pulse_state st=%0d coin=%b want 1/0", st, p1[0]); end
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (p1[0] !== 1'b1 || st !== 2'd0 || cc !== 8'h00)
      begin n_fail++; $display("FAIL mid_pulse_abort coin=%b st=%0d cc=%0d want 1/0/0", p1[0], st, cc); end
    rst_n = 1'b1; found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk);
      n_tests++;
      if (p1 !== m_p1) begin n_fail++; $display("FAIL mid_pulse_redeb p1=%h want %h", p1, m_p1); end
      if (p1[0] == 1'b0) found = 1;
    end
    n_tests++;
    if (found == 0 || cc !== exp_cc_const(1))
      begin n_fail++; $display("FAIL mid_pulse_restart found=%0d cc=%0d want 1/%0d", found, cc, exp_cc_const(1)); end
    joy = 16'h0000;
    repeat (25) @(negedge clk);
  endtask

  task automatic test_random();
    int hold;
    rst_n = 1'b0; joy = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int it = 0; it < 120; it++) begin
      joy  = 16'($urandom);
      hold = $urandom_range(1, 12);
      rst_n = ($urandom_range(0, 29) != 0);
      repeat (hold) begin
        @(negedge clk);
        rst_n = 1'b1;
        n_tests++;
        if (p1 !== m_p1 || pause_o !== m_pause || cc !== exp_cc() || st !== exp_phase())
          begin
            n_fail++;
            $display("FAIL random p1=%h/%h pause=%b/%b cc=%0d/%0d st=%0d/%0d (got/want)",
                     p1, m_p1, pause_o, m_pause, cc, exp_cc(), st, exp_phase());
          end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    joy   = 16'h0000;
    test_reset();
    test_debounce();
    test_directions();
    test_coin();
    test_pause();
    test_reset_mid_pulse();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
